// File: rtl/db_top_ram_ctrl.sv
// db_top_ram_ctrl: drives one port of the deblocking top-pixel RAM through
// each LCU in three phases: LOAD top neighbours from fetch, FILT (arbitrated
// filter reads and writes), and DUMP every line to the store stream.
//
// Handshakes: a load line moves on a cycle where ld_valid_i && ld_ready_o;
// a store line moves on a cycle where st_valid_o && st_ready_i; rd_ack_o and
// wr_ack_o are combinational grants for the request held in that same cycle.
// Once st_valid_o is raised it stays high until the line is taken.
module db_top_ram_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_ack_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ack_o,
    input  logic                  filt_done_i,
    output logic                  st_valid_o,
    input  logic                  st_ready_i,
    output logic [DATA_WIDTH-1:0] st_data_o,
    output logic                  ram_cen_o,
    output logic                  ram_wen_o,
    output logic                  ram_ren_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         N_LINES   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILT = 2'd2,
        S_DUMP = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;          // LOAD line / DUMP issue counter
    logic [ADDR_WIDTH-1:0] pop_cnt_q, pop_cnt_d;  // DUMP lines handed to store
    logic                  wr_pri_q, wr_pri_d;    // 1: write wins a tie
    logic                  filt_rd_q, filt_rd_d;  // filter read in flight
    logic                  dump_rd_q, dump_rd_d;  // dump read in flight

    // Two-entry store buffer
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  fifo_wp_q, fifo_rp_q;
    logic [1:0]            occ_q;
    logic                  fifo_pop;
    logic                  issue_ok;

    logic                  ram_acc, ram_wr;
    logic                  grant_wr, grant_rd;

    assign fifo_pop = (occ_q != 2'd0) && st_ready_i;
    // Room check: buffered + in flight, less what leaves this cycle, stays below 2
    assign issue_ok = (({1'b0, occ_q} + {2'b00, dump_rd_q}) < (3'd2 + {2'b00, fifo_pop}));

    // Next-state, grants and RAM port control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pop_cnt_d  = pop_cnt_q;
        wr_pri_d   = wr_pri_q;
        filt_rd_d  = 1'b0;
        dump_rd_d  = 1'b0;
        ld_ready_o = 1'b0;
        rd_ack_o   = 1'b0;
        wr_ack_o   = 1'b0;
        done_o     = 1'b0;
        ram_acc    = 1'b0;
        ram_wr     = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end

            S_LOAD: begin
                ld_ready_o = 1'b1;
                if (ld_valid_i) begin
                    ram_acc    = 1'b1;
                    ram_wr     = 1'b1;
                    ram_addr_o = cnt_q[ADDR_WIDTH-1:0];
                    ram_data_o = ld_data_i;
                    cnt_d      = cnt_q + CW'(1);
                    if (cnt_q[ADDR_WIDTH-1:0] == LAST_LINE) begin
                        state_d = S_FILT;
                        cnt_d   = '0;
                    end
                end
            end

            S_FILT: begin
                if (filt_done_i) begin
                    // Requests in this cycle are dropped without an ack
                    state_d   = S_DUMP;
                    cnt_d     = '0;
                    pop_cnt_d = '0;
                end else begin
                    grant_wr = wr_req_i && (!rd_req_i || wr_pri_q);
                    grant_rd = rd_req_i && !grant_wr;
                    if (grant_wr) begin
                        wr_ack_o   = 1'b1;
                        ram_acc    = 1'b1;
                        ram_wr     = 1'b1;
                        ram_addr_o = wr_addr_i;
                        ram_data_o = wr_data_i;
                        wr_pri_d   = 1'b0;
                    end
                    if (grant_rd) begin
                        rd_ack_o   = 1'b1;
                        ram_acc    = 1'b1;
                        ram_addr_o = rd_addr_i;
                        filt_rd_d  = 1'b1;
                        wr_pri_d   = 1'b1;
                    end
                end
            end

            S_DUMP: begin
                if ((cnt_q < N_LINES) && issue_ok) begin
                    ram_acc    = 1'b1;
                    ram_addr_o = cnt_q[ADDR_WIDTH-1:0];
                    dump_rd_d  = 1'b1;
                    cnt_d      = cnt_q + CW'(1);
                end
                if (fifo_pop) begin
                    pop_cnt_d = pop_cnt_q + ADDR_WIDTH'(1);
                    if (pop_cnt_q == LAST_LINE) begin
                        done_o  = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign ram_cen_o  = !ram_acc;
    assign ram_wen_o  = !ram_wr;
    assign ram_ren_o  = !(filt_rd_q || dump_rd_q);
    assign rd_valid_o = filt_rd_q;
    assign rd_data_o  = ram_data_i;
    assign busy_o     = (state_q != S_IDLE);
    assign st_valid_o = (occ_q != 2'd0);
    assign st_data_o  = fifo_q[fifo_rp_q];

    // State, counters, arbitration pointer and in-flight flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pop_cnt_q <= '0;
            wr_pri_q  <= 1'b1;
            filt_rd_q <= 1'b0;
            dump_rd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pop_cnt_q <= pop_cnt_d;
            wr_pri_q  <= wr_pri_d;
            filt_rd_q <= filt_rd_d;
            dump_rd_q <= dump_rd_d;
        end
    end

    // Store buffer: returning dump data is pushed, store handshake pops
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            fifo_wp_q <= 1'b0;
            fifo_rp_q <= 1'b0;
            occ_q     <= 2'd0;
        end else begin
            if (dump_rd_q) begin
                fifo_q[fifo_wp_q] <= ram_data_i;
                fifo_wp_q         <= !fifo_wp_q;
            end
            if (fifo_pop) begin
                fifo_rp_q <= !fifo_rp_q;
            end
            occ_q <= occ_q + {1'b0, dump_rd_q} - {1'b0, fifo_pop};
        end
    end

endmodule

// File: tb/tb_db_top_ram_ctrl.sv
// Bench for db_top_ram_ctrl: directed LCU sequences against a simple RAM
// model, with queues of expected RAM writes, filter reads and store lines.
module tb_db_top_ram_ctrl;

    localparam int DW = 128;
    localparam int AW = 5;
    localparam int N  = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_i, busy_o, done_o;
    logic          ld_valid_i, ld_ready_o;
    logic [DW-1:0] ld_data_i;
    logic          rd_req_i, rd_ack_o, rd_valid_o;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_o;
    logic          wr_req_i, wr_ack_o;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          filt_done_i;
    logic          st_valid_o, st_ready_i;
    logic [DW-1:0] st_data_o;
    logic          ram_cen_o, ram_wen_o, ram_ren_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_data_o, ram_data_i;

    db_top_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .wr_ack_o(wr_ack_o), .filt_done_i(filt_done_i),
        .st_valid_o(st_valid_o), .st_ready_i(st_ready_i), .st_data_o(st_data_o),
        .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o), .ram_ren_o(ram_ren_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
    );

    // Single-port RAM model with one cycle of read latency
    logic [DW-1:0] ram_mem [N];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) ram_mem[ram_addr_o] <= ram_data_o;
            else            ram_q <= ram_mem[ram_addr_o];
        end
    end
    assign ram_data_i = ram_q;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [AW+DW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_rd_q[$];
    logic [DW-1:0]    exp_st_q[$];
    logic [DW-1:0]    exp_mem [N];

    bit dump_phase = 1'b0;
    int dump_issued, dump_popped, max_out;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    task automatic check(input string name, input logic [AW+DW-1:0] act,
                         input logic [AW+DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst) begin
            if (!ram_cen_o && !ram_wen_o) begin
                if (exp_wr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ram_write actual=addr %0d required=no write", ram_addr_o);
                end else begin
                    check("ram_write", {ram_addr_o, ram_data_o}, exp_wr_q.pop_front());
                end
            end
            if (dump_phase) begin
                if (!ram_cen_o && ram_wen_o) begin
                    check("dump_rd_addr", ram_addr_o, dump_issued);
                    dump_issued++;
                end
                if (st_valid_o && st_ready_i) dump_popped++;
                if (dump_issued - dump_popped > max_out) max_out = dump_issued - dump_popped;
            end
            if (rd_valid_o) begin
                if (exp_rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_valid actual=1 required=0");
                end else begin
                    check("rd_data", rd_data_o, exp_rd_q.pop_front());
                end
            end
            if (st_valid_o && st_ready_i) begin
                if (exp_st_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL st_line actual=extra line required=none");
                end else begin
                    check("st_data", st_data_o, exp_st_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     busy_o,     0);
        check({tag, "_done"},     done_o,     0);
        check({tag, "_ld_ready"}, ld_ready_o, 0);
        check({tag, "_rd_ack"},   rd_ack_o,   0);
        check({tag, "_wr_ack"},   wr_ack_o,   0);
        check({tag, "_rd_valid"}, rd_valid_o, 0);
        check({tag, "_st_valid"}, st_valid_o, 0);
        check({tag, "_cen"},      ram_cen_o,  1);
        check({tag, "_wen"},      ram_wen_o,  1);
        check({tag, "_ren"},      ram_ren_o,  1);
        check({tag, "_addr"},     ram_addr_o, 0);
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        @(negedge clk);
        check("load_ld_ready", ld_ready_o, 1);
        check("load_busy", busy_o, 1);
        tick();
    endtask

    // Each line i carries the byte (base+i) replicated
    task automatic load_lines(input logic [7:0] base, input bit toggle);
        int i = 0;
        int cyc = 0;
        logic [7:0]    b;
        logic [DW-1:0] d;
        while (i < N && cyc < 200) begin
            if (!toggle || (cyc % 2 == 0)) begin
                b = base + 8'(i);
                d = {16{b}};
                ld_valid_i = 1'b1;
                ld_data_i  = d;
                exp_wr_q.push_back({AW'(i), d});
                exp_mem[i] = d;
            end else begin
                ld_valid_i = 1'b0;
            end
            @(negedge clk);
            tick();
            if (ld_valid_i) i++;
            cyc++;
        end
        ld_valid_i = 1'b0;
        if (i < N) begin
            checks++; failures++;
            $display("FAIL load_timeout actual=%0d lines required=%0d", i, N);
        end
        @(negedge clk);
        check("filt_entry_ld_ready", ld_ready_o, 0);
        check("filt_entry_busy", busy_o, 1);
        check("load_writes_drained", exp_wr_q.size(), 0);
        tick();
    endtask

    // Filter-done cycle: no grant, then DUMP; caller may hold requests high
    task automatic enter_dump();
        filt_done_i = 1'b1;
        for (int a = 0; a < N; a++) exp_st_q.push_back(exp_mem[a]);
        dump_issued = 0;
        dump_popped = 0;
        max_out     = 0;
        dump_phase  = 1'b1;
        @(negedge clk);
        check("fdone_rd_ack", rd_ack_o, 0);
        check("fdone_wr_ack", wr_ack_o, 0);
        check("fdone_cen", ram_cen_o, 1);
        tick();
        filt_done_i = 1'b0;
        rd_req_i    = 1'b0;
        wr_req_i    = 1'b0;
    endtask

    task automatic run_dump(input bit use_pat, input int abort_after,
                            output int first_valid, output int done_cyc,
                            output int done_cnt);
        int  lpops = 0;
        bit  fin = 1'b0;
        first_valid = -1;
        done_cyc    = -1;
        done_cnt    = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            st_ready_i = use_pat ? pat[cyc % 6] : 1'b1;
            @(negedge clk);
            if (st_valid_o && first_valid < 0) first_valid = cyc;
            if (st_valid_o && st_ready_i) lpops++;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                fin = 1'b1;
            end
            if (abort_after > 0 && lpops == abort_after) fin = 1'b1;
            tick();
        end
        if (!fin) begin
            checks++; failures++;
            $display("FAIL dump_timeout actual=%0d pops required=done", lpops);
        end
    endtask

    task automatic finish_dump(input string tag, input int done_cnt_in);
        int dc = done_cnt_in;
        st_ready_i = 1'b0;
        @(negedge clk);
        check({tag, "_busy_fall"}, busy_o, 0);
        check({tag, "_done_once"}, done_o, 0);
        tick();
        repeat (3) begin
            @(negedge clk);
            if (done_o) dc++;
            tick();
        end
        dump_phase = 1'b0;
        check({tag, "_done_count"}, dc, 1);
        check({tag, "_lines_left"}, exp_st_q.size(), 0);
        check({tag, "_reads_issued"}, dump_issued, N);
        check({tag, "_max_outstanding_gt2"}, (max_out > 2), 0);
    endtask

    // ---------------- main sequence ----------------
    int fv, dcyc, dcnt;

    initial begin
        rst = 1'b1;
        start_i = 0; ld_valid_i = 0; ld_data_i = '0;
        rd_req_i = 0; rd_addr_i = '0; wr_req_i = 0; wr_addr_i = '0; wr_data_i = '0;
        filt_done_i = 0; st_ready_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        tick();
        rst = 1'b0;
        tick();

        // Run 1: continuous load, filter traffic, dump with backpressure
        do_start();
        load_lines(8'h00, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic [7:0]    b;
            logic [DW-1:0] d;
            bit            exp_w;
            b = 8'hA0 + 8'(k);
            d = {16{b}};
            exp_w = (k % 2 == 0);
            rd_req_i = 1'b1; rd_addr_i = 5'd3;
            wr_req_i = 1'b1; wr_addr_i = 5'd3; wr_data_i = d;
            if (exp_w) begin
                exp_wr_q.push_back({5'd3, d});
                exp_mem[3] = d;
            end else begin
                exp_rd_q.push_back(exp_mem[3]);
            end
            @(negedge clk);
            check($sformatf("arb%0d_wr_ack", k), wr_ack_o, exp_w);
            check($sformatf("arb%0d_rd_ack", k), rd_ack_o, !exp_w);
            tick();
        end
        rd_req_i = 1'b0;
        wr_req_i = 1'b0;
        tick();

        rd_req_i = 1'b1; rd_addr_i = 5'd7;
        exp_rd_q.push_back(exp_mem[7]);
        @(negedge clk);
        check("rd7_ack", rd_ack_o, 1);
        check("rd7_addr", ram_addr_o, 7);
        check("rd7_cen", ram_cen_o, 0);
        check("rd7_wen", ram_wen_o, 1);
        tick();
        rd_req_i = 1'b0;
        @(negedge clk);
        check("rd7_valid", rd_valid_o, 1);
        check("rd7_ren", ram_ren_o, 0);
        tick();

        start_i = 1'b1;
        @(negedge clk);
        check("start_in_filt_cen", ram_cen_o, 1);
        check("start_in_filt_ld_ready", ld_ready_o, 0);
        tick();
        start_i = 1'b0;
        wr_req_i = 1'b1; wr_addr_i = 5'd5; wr_data_i = {16{8'h55}};
        exp_wr_q.push_back({5'd5, {16{8'h55}}});
        exp_mem[5] = {16{8'h55}};
        @(negedge clk);
        check("still_filt_wr_ack", wr_ack_o, 1);
        check("still_filt_busy", busy_o, 1);
        tick();
        wr_req_i = 1'b0;

        rd_req_i = 1'b1; rd_addr_i = 5'd9;
        exp_rd_q.push_back(exp_mem[9]);
        @(negedge clk);
        check("rd9_ack", rd_ack_o, 1);
        tick();
        rd_req_i = 1'b1; wr_req_i = 1'b1;
        enter_dump();
        run_dump(1'b1, 0, fv, dcyc, dcnt);
        check("dump1_first_valid", fv, 2);
        finish_dump("dump1", dcnt);
        check("rd_drained", exp_rd_q.size(), 0);

        // filt_done and requests in IDLE are ignored
        filt_done_i = 1'b1; rd_req_i = 1'b1; wr_req_i = 1'b1;
        @(negedge clk);
        check("idle_fdone_rd_ack", rd_ack_o, 0);
        check("idle_fdone_wr_ack", wr_ack_o, 0);
        check("idle_fdone_cen", ram_cen_o, 1);
        tick();
        filt_done_i = 1'b0; rd_req_i = 1'b0; wr_req_i = 1'b0;
        @(negedge clk);
        check("idle_fdone_busy", busy_o, 0);
        tick();

        // Run 2: toggling load, then reset after 10 store pops
        do_start();
        load_lines(8'h40, 1'b1);
        enter_dump();
        run_dump(1'b0, 10, fv, dcyc, dcnt);
        rst = 1'b1;
        st_ready_i = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        check("abort_lines_left", exp_st_q.size(), N - 10);
        exp_st_q.delete();
        dump_phase = 1'b0;
        tick();

        // Run 3: fresh full load and dump with the sink always ready
        do_start();
        load_lines(8'h80, 1'b0);
        enter_dump();
        run_dump(1'b0, 0, fv, dcyc, dcnt);
        check("dump3_first_valid", fv, 2);
        check("dump3_done_cycle", dcyc, N + 1);
        finish_dump("dump3", dcnt);

        check("end_wr_q_empty", exp_wr_q.size(), 0);
        check("end_rd_q_empty", exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
